alu_arbiter: RTL and testbench

Two-requester arbiter and issue sequencer for the shared 32-bit combinational ALU (the ALU takes operands `a`/`b` and a 4-bit `aluctrl`, and returns `aluOut` and `zero`). It sits between the execute stage (requester 0) and the branch/address unit (requester 1). It grants one request per cycle by round-robin, registers the winning operands into the ALU input stage, and captures the ALU result into a response register. The response register is tagged with the requester id and back-pressured by a single ready.

---
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter and two-stage issue
// sequencer in front of a shared combinational ALU.
//   S1: granted operands registered onto the ALU input port.
//   S2: ALU result captured into a tagged response register.
// Optional feature: define ALU_ARB_DIVZ_CHK_EN to trap divide-by-zero
// (ctrl == 5 with b == 0) and report it through rsp_err.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. On the request side valid is reqN
// and ready is gntN; the requester holds reqN and its operands stable
// until that edge. On the response side valid is rsp_valid and ready is
// rsp_ready; rsp_* stays stable while rsp_valid is high and rsp_ready is
// low. A response that is accepted may be replaced on the same edge.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [WIDTH-1:0]  a0,
  input  logic [WIDTH-1:0]  b0,
  input  logic [WIDTH-1:0]  a1,
  input  logic [WIDTH-1:0]  b1,
  input  logic [CTRL_W-1:0] ctrl0,
  input  logic [CTRL_W-1:0] ctrl1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic              busy
);

  logic              stall;
  logic              xfer;
  logic              last_id;
  logic              s1_v;
  logic              s1_id;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [CTRL_W-1:0] sel_ctrl;

  // The whole pipeline freezes while a response waits for its consumer.
  assign stall = rsp_valid & ~rsp_ready;
  assign xfer  = gnt0 | gnt1;
  assign busy  = s1_v | rsp_valid;

  // Round-robin grant: a lone requester wins; on a tie the requester that
  // did not win last time is served. No grants under stall or reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!stall && !reset) begin
      gnt0 = req0 & (~req1 | last_id);
      gnt1 = req1 & (~req0 | ~last_id);
    end
  end

  // Operand mux driven by the winning grant.
  always_comb begin
    sel_a    = a0;
    sel_b    = b0;
    sel_ctrl = ctrl0;
    if (gnt1) begin
      sel_a    = a1;
      sel_b    = b1;
      sel_ctrl = ctrl1;
    end
  end

  // Round-robin history: remembers the id of the most recent transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_id <= 1'b1;
    end else if (xfer) begin
      last_id <= gnt1;
    end
  end

`ifdef ALU_ARB_DIVZ_CHK_EN
  localparam logic [CTRL_W-1:0] OP_DIV = CTRL_W'(5);

  logic sel_dz;
  logic s1_dz;
  logic dz_cap;

  // A divide by zero still flows through the ALU, but with a safe divisor.
  assign sel_dz = (sel_ctrl == OP_DIV) && (sel_b == '0);
  assign dz_cap = s1_v & s1_dz;

  // S1: load the granted op; a cycle without a transfer empties the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v     <= 1'b0;
      s1_id    <= 1'b0;
      s1_dz    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
    end else if (!stall) begin
      s1_v <= xfer;
      if (xfer) begin
        s1_id    <= gnt1;
        s1_dz    <= sel_dz;
        alu_a    <= sel_a;
        alu_b    <= sel_dz ? WIDTH'(1) : sel_b;
        alu_ctrl <= sel_ctrl;
      end
    end
  end

  // S2: capture the ALU result, overriding it for a trapped divide.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (!stall) begin
      rsp_valid <= s1_v;
      rsp_id    <= s1_id;
      rsp_data  <= dz_cap ? '1 : alu_out;
      rsp_zero  <= dz_cap ? 1'b0 : alu_zero;
      rsp_err   <= dz_cap;
    end
  end
`else
  assign rsp_err = 1'b0;

  // S1: load the granted op; a cycle without a transfer empties the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v     <= 1'b0;
      s1_id    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
    end else if (!stall) begin
      s1_v <= xfer;
      if (xfer) begin
        s1_id    <= gnt1;
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        alu_ctrl <= sel_ctrl;
      end
    end
  end

  // S2: capture the ALU result tagged with its owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else if (!stall) begin
      rsp_valid <= s1_v;
      rsp_id    <= s1_id;
      rsp_data  <= alu_out;
      rsp_zero  <= alu_zero;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU.
module tb_alu_arbiter;

  localparam int W = 32;
  localparam int C = 4;

  logic         clk;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [C-1:0] ctrl0, ctrl1;
  logic         gnt0, gnt1;
  logic [W-1:0] alu_a, alu_b;
  logic [C-1:0] alu_ctrl;
  logic [W-1:0] alu_out;
  logic         alu_zero;
  logic         rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_ready, busy;
  logic [W-1:0] rsp_data;

  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;
  logic [33:0] exp_q[$];

  alu_arbiter #(.WIDTH(W), .CTRL_W(C)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ctrl0(ctrl0), .ctrl1(ctrl1),
    .gnt0(gnt0), .gnt1(gnt1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU attached to the arbiter's ALU port
  always_comb begin
    case (alu_ctrl)
      4'd0:    alu_out = alu_a & alu_b;
      4'd1:    alu_out = alu_a | alu_b;
      4'd2:    alu_out = alu_a + alu_b;
      4'd5:    alu_out = (alu_b == 0) ? 32'd0 : alu_a / alu_b;
      4'd6:    alu_out = alu_a - alu_b;
      4'd7:    alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'd10:   alu_out = alu_a - alu_b;
      4'd12:   alu_out = ~(alu_a | alu_b);
      default: alu_out = 32'd0;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: act=%0h req=%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    ctrl0 = '0; ctrl1 = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [C-1:0] ctrl);
    if (id) begin
      req1 = 1'b1; a1 = a; b1 = b; ctrl1 = ctrl; req0 = 1'b0;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b; ctrl0 = ctrl; req1 = 1'b0;
    end
  endtask

  // Scoreboard: every accepted response must match the queue head
  always @(negedge clk) begin
    #2;
    if (mon_en && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {rsp_id, rsp_zero, rsp_data}, 34'h0);
        chk("rsp_unexpected_valid", {33'd0, rsp_valid}, 34'd0);
      end else begin
        chk("rsp_order", {rsp_id, rsp_zero, rsp_data}, exp_q.pop_front());
      end
    end
  end

  // Both requesters hold fixed ops; per-cycle ready and expected grant schedule
  localparam logic [33:0] OP0_EXP = {1'b0, 1'b1, 32'd0};
  localparam logic [33:0] OP1_EXP = {1'b1, 1'b0, 32'd9};

  task automatic run_pair(input string tag, input int n, input logic [15:0] rdy,
                          input logic [31:0] gsch);
    logic [1:0]   eg;
    logic         have_snap;
    logic [33:0]  snap;
    have_snap = 1'b0;
    snap = '0;
    mon_en = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      req0 = 1'b1; a0 = 32'd3; b0 = 32'd3; ctrl0 = 4'd10;
      req1 = 1'b1; a1 = 32'd8; b1 = 32'd1; ctrl1 = 4'd1;
      rsp_ready = rdy[c];
      #1;
      eg = gsch[2*c +: 2];
      chk($sformatf("%s_gnt_c%0d", tag, c), {32'd0, gnt1, gnt0}, {32'd0, eg});
      if (eg == 2'b01) exp_q.push_back(OP0_EXP);
      if (eg == 2'b10) exp_q.push_back(OP1_EXP);
      if (!rdy[c]) begin
        chk($sformatf("%s_stall_valid_c%0d", tag, c), {33'd0, rsp_valid}, 34'd1);
        if (!have_snap) begin
          snap = {rsp_id, rsp_zero, rsp_data};
          have_snap = 1'b1;
        end else begin
          chk($sformatf("%s_stall_hold_c%0d", tag, c), {rsp_id, rsp_zero, rsp_data}, snap);
        end
      end
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #3;
    end
    chk({tag, "_drain"}, 34'(exp_q.size()), 34'd0);
    @(negedge clk);
    #1;
    chk({tag, "_idle_busy"}, {33'd0, busy}, 34'd0);
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  // Single-op vector table
  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [C-1:0] ctrl;
    logic [W-1:0] exp_alu_b;
    logic [W-1:0] exp_data;
    logic         exp_zero;
    logic         exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    reset = 1'b1;
    idle_inputs();

    vecs[0] = '{1'b0, 32'd7,  32'd5,          4'd2,  32'd5,          32'd12, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'd10, 32'hFFFF_FFFD,  4'd2,  32'hFFFF_FFFD,  32'd7,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'd3,  32'd3,          4'd10, 32'd3,          32'd0,  1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'd8,  32'd1,          4'd1,  32'd1,          32'd9,  1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'd12, 32'd10,         4'd0,  32'd10,         32'd8,  1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'd5,  32'd5,          4'd6,  32'd5,          32'd0,  1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'd20, 32'd4,          4'd5,  32'd4,          32'd5,  1'b0, 1'b0};
`ifdef ALU_ARB_DIVZ_CHK_EN
    vecs[7] = '{1'b0, 32'd9,  32'd0,          4'd5,  32'd1,          32'hFFFF_FFFF, 1'b0, 1'b1};
`else
    vecs[7] = '{1'b0, 32'd9,  32'd0,          4'd5,  32'd0,          32'd0,  1'b1, 1'b0};
`endif
    vecs[8] = '{1'b1, 32'd1,  32'd2,          4'd15, 32'd2,          32'd0,  1'b1, 1'b0};

    // Reset state: no grants with both requesting, all outputs cleared
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_gnt", {32'd0, gnt1, gnt0}, 34'd0);
    chk("reset_alu_a", {2'd0, alu_a}, 34'd0);
    chk("reset_alu_b", {2'd0, alu_b}, 34'd0);
    chk("reset_alu_ctrl", {30'd0, alu_ctrl}, 34'd0);
    chk("reset_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_err, busy, rsp_data[28:0]}, 34'd0);
    do_reset();

    // Table: one op at a time, grant / S1 / S2 checked at fixed latency
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].ctrl);
      #1;
      chk($sformatf("v%0d_gnt", i), {32'd0, gnt1, gnt0},
          {32'd0, vecs[i].id, ~vecs[i].id});
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      #1;
      chk($sformatf("v%0d_alu_a", i), {2'd0, alu_a}, {2'd0, vecs[i].a});
      chk($sformatf("v%0d_alu_b", i), {2'd0, alu_b}, {2'd0, vecs[i].exp_alu_b});
      chk($sformatf("v%0d_alu_ctrl", i), {30'd0, alu_ctrl}, {30'd0, vecs[i].ctrl});
      chk($sformatf("v%0d_busy_s1", i), {33'd0, busy}, 34'd1);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), {33'd0, rsp_valid}, 34'd1);
      chk($sformatf("v%0d_rsp_id", i), {33'd0, rsp_id}, {33'd0, vecs[i].id});
      chk($sformatf("v%0d_rsp_data", i), {2'd0, rsp_data}, {2'd0, vecs[i].exp_data});
      chk($sformatf("v%0d_rsp_zero", i), {33'd0, rsp_zero}, {33'd0, vecs[i].exp_zero});
      chk($sformatf("v%0d_rsp_err", i), {33'd0, rsp_err}, {33'd0, vecs[i].exp_err});
    end

    // Contention: grants alternate 0,1,0,1 with back-to-back responses
    do_reset();
    run_pair("cont", 4, 16'hFFFF, 32'h0000_0099);

    // Backpressure: ready low for 3 cycles while both keep requesting
    do_reset();
    run_pair("bp", 8, 16'h00E3, 32'h0000_6409);

    // Reset one edge after a grant: the in-flight op must vanish
    do_reset();
    @(negedge clk);
    drive_op(1'b0, 32'd4, 32'd6, 4'd2);
    #1;
    chk("rmf_gnt", {32'd0, gnt1, gnt0}, 34'b01);
    @(negedge clk);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("rmf_gnt_in_reset", {32'd0, gnt1, gnt0}, 34'd0);
    @(negedge clk);
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("rmf_rsp_valid", {33'd0, rsp_valid}, 34'd0);
    chk("rmf_busy", {33'd0, busy}, 34'd0);
    chk("rmf_alu_a", {2'd0, alu_a}, 34'd0);
    chk("rmf_alu_b", {2'd0, alu_b}, 34'd0);
    chk("rmf_alu_ctrl", {30'd0, alu_ctrl}, 34'd0);
    chk("rmf_rsp_regs", {rsp_id, rsp_zero, rsp_data}, 34'd0);
    @(negedge clk);
    #1;
    chk("rmf_no_late_rsp", {33'd0, rsp_valid}, 34'd0);
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("rmf_tie_after_reset", {32'd0, gnt1, gnt0}, 34'b01);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
